// File: rtl/cordic_rotation_core.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, returning sin/cos of a
// Q3.13 angle as Q1.14 values, with quadrant folding and out-of-range flagging.
module cordic_rotation_core #(
  parameter int WIDTH  = 16,
  parameter int ITER   = 16,
  parameter int K_INIT = 9949
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             start,
  input  logic [WIDTH-1:0] angle_in,
  output logic             busy,
  output logic             done,
  output logic             err_range,
  output logic [WIDTH-1:0] sin_out,
  output logic [WIDTH-1:0] cos_out
);

  localparam int IW = WIDTH + 2;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic signed [IW-1:0] C_PI   = IW'(25736);
  localparam logic signed [IW-1:0] C_HALF = IW'(12868);
  localparam logic signed [IW-1:0] C_ONE  = IW'(1 << (WIDTH - 2));
  localparam logic signed [IW-1:0] C_K    = IW'(K_INIT);
  localparam logic [CW-1:0]        C_LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROTATE, S_FINISH} state_t;

  state_t                 r_state;
  logic signed [IW-1:0]   r_angle;
  logic signed [IW-1:0]   r_x;
  logic signed [IW-1:0]   r_y;
  logic signed [IW-1:0]   r_z;
  logic [CW-1:0]          r_iter;
  logic                   r_flip;
  logic                   r_err;

  // round(atan(2^-i) * 8192); entries beyond 13 round to zero.
  function automatic logic signed [IW-1:0] atan_lut(input int idx);
    case (idx)
      0:       return IW'(6434);
      1:       return IW'(3798);
      2:       return IW'(2007);
      3:       return IW'(1019);
      4:       return IW'(511);
      5:       return IW'(256);
      6:       return IW'(128);
      7:       return IW'(64);
      8:       return IW'(32);
      9:       return IW'(16);
      10:      return IW'(8);
      11:      return IW'(4);
      12:      return IW'(2);
      13:      return IW'(1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] sat_one(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] t;
    if (v > C_ONE)       t = C_ONE;
    else if (v < -C_ONE) t = -C_ONE;
    else                 t = v;
    return t[WIDTH-1:0];
  endfunction

  logic                 w_dpos;
  logic signed [IW-1:0] w_xs;
  logic signed [IW-1:0] w_ys;
  logic signed [IW-1:0] w_atan;
  logic signed [IW-1:0] w_x_next;
  logic signed [IW-1:0] w_y_next;
  logic signed [IW-1:0] w_z_next;
  logic                 w_err;
  logic signed [IW-1:0] w_cos_raw;
  logic signed [IW-1:0] w_sin_raw;

  assign w_dpos    = ~r_z[IW-1];
  assign w_xs      = r_x >>> r_iter;
  assign w_ys      = r_y >>> r_iter;
  assign w_atan    = atan_lut(int'(r_iter));
  assign w_x_next  = w_dpos ? (r_x - w_ys)   : (r_x + w_ys);
  assign w_y_next  = w_dpos ? (r_y + w_xs)   : (r_y - w_xs);
  assign w_z_next  = w_dpos ? (r_z - w_atan) : (r_z + w_atan);
  assign w_err     = (r_angle > C_PI) || (r_angle < -C_PI);
  assign w_cos_raw = r_flip ? -r_x : r_x;
  assign w_sin_raw = r_flip ? -r_y : r_y;

  // NOTE: every state bit is cleared by reset so an aborted run leaves nothing behind;
  // non-blocking assignments keep all registers updating from the same pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_angle   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_iter    <= '0;
      r_flip    <= 1'b0;
      r_err     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_range <= 1'b0;
      sin_out   <= '0;
      cos_out   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_angle   <= {{2{angle_in[WIDTH-1]}}, angle_in};
            busy      <= 1'b1;
            err_range <= 1'b0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_x    <= C_K;
          r_y    <= '0;
          r_iter <= '0;
          r_err  <= w_err;
          if (w_err) begin
            r_z    <= '0;
            r_flip <= 1'b0;
          end else if (r_angle > C_HALF) begin
            r_z    <= r_angle - C_PI;
            r_flip <= 1'b1;
          end else if (r_angle < -C_HALF) begin
            r_z    <= r_angle + C_PI;
            r_flip <= 1'b1;
          end else begin
            r_z    <= r_angle;
            r_flip <= 1'b0;
          end
          r_state <= S_ROTATE;
        end
        S_ROTATE: begin
          r_x <= w_x_next;
          r_y <= w_y_next;
          r_z <= w_z_next;
          if (r_iter == C_LAST) r_state <= S_FINISH;
          else                  r_iter  <= r_iter + 1'b1;
        end
        S_FINISH: begin
          sin_out   <= r_err ? '0 : sat_one(w_sin_raw);
          cos_out   <= r_err ? '0 : sat_one(w_cos_raw);
          err_range <= r_err;
          done      <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotation_core.sv
// Directed bench for cordic_rotation_core: latency, busy/done handshake, fold, range
// error, ignored mid-run start and asynchronous abort.
module tb_cordic_rotation_core;

  localparam int WIDTH = 16;
  localparam int ITER  = 16;
  localparam int LAT   = ITER + 2;
  localparam int TOL   = 4;

  logic                    ACLK = 1'b0;
  logic                    ARESET = 1'b1;
  logic                    start = 1'b0;
  logic signed [WIDTH-1:0] angle_in = '0;
  logic                    busy;
  logic                    done;
  logic                    err_range;
  logic signed [WIDTH-1:0] sin_out;
  logic signed [WIDTH-1:0] cos_out;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  cordic_rotation_core #(.WIDTH(WIDTH), .ITER(ITER), .K_INIT(9949)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .start     (start),
    .angle_in  (angle_in),
    .busy      (busy),
    .done      (done),
    .err_range (err_range),
    .sin_out   (sin_out),
    .cos_out   (cos_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp);
    int diff;
    diff = obs - exp;
    total++;
    assert ((diff <= TOL && diff >= -TOL) === 1'b1) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d +/- %0d", tag, obs, exp, TOL);
    end
  endtask

  // Issue one command, optionally inject a second start inj_at cycles after acceptance,
  // and return the edge count to done and whether busy stayed high until then.
  task automatic run_cmd(input int angle, input int inj_at, input int inj_angle,
                         output int lat, output int busy_ok);
    @(negedge ACLK);
    start    = 1'b1;
    angle_in = WIDTH'(angle);
    @(negedge ACLK);
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1;
    while (!done && lat < 60) begin
      if (!busy) busy_ok = 0;
      if (lat == inj_at) begin
        start    = 1'b1;
        angle_in = WIDTH'(inj_angle);
      end else begin
        start = 1'b0;
      end
      @(negedge ACLK);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge ACLK);
      if (done) seen++;
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input int busy_ok,
                               input int exp_cos, input int exp_sin);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_busy_run"}, busy_ok, 1);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_err"}, int'(err_range), 0);
    check_tol({tag, "_cos"}, int'(cos_out), exp_cos);
    check_tol({tag, "_sin"}, int'(sin_out), exp_sin);
    @(negedge ACLK);
    check({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int lat;
    int bok;
    int seen;

    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;

    count_done(10, seen);
    check("idle_done", seen, 0);
    check("idle_busy", int'(busy), 0);
    check("idle_err", int'(err_range), 0);
    check("idle_sin", int'(sin_out), 0);
    check("idle_cos", int'(cos_out), 0);

    run_cmd(0, -1, 0, lat, bok);
    expect_result("zero", lat, bok, 16384, 0);

    run_cmd(4289, -1, 0, lat, bok);
    expect_result("pi6", lat, bok, 14189, 8192);

    run_cmd(12868, -1, 0, lat, bok);
    expect_result("pi2", lat, bok, 0, 16384);

    run_cmd(-19302, -1, 0, lat, bok);
    expect_result("m3pi4", lat, bok, -11585, -11585);

    run_cmd(30000, -1, 0, lat, bok);
    check("range_latency", lat, LAT);
    check("range_err", int'(err_range), 1);
    check("range_sin", int'(sin_out), 0);
    check("range_cos", int'(cos_out), 0);
    @(negedge ACLK);
    check("range_err_held", int'(err_range), 1);

    // A start pulsed mid-run must neither restart nor queue a second result.
    run_cmd(4289, 5, 12868, lat, bok);
    expect_result("ignore", lat, bok, 14189, 8192);
    count_done(30, seen);
    check("ignore_no_2nd_done", seen, 0);
    check_tol("ignore_cos_held", int'(cos_out), 14189);

    @(negedge ACLK);
    start    = 1'b1;
    angle_in = '0;
    @(negedge ACLK);
    start = 1'b0;
    repeat (7) @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_sin", int'(sin_out), 0);
    check("abort_cos", int'(cos_out), 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    count_done(30, seen);
    check("abort_no_done", seen, 0);
    check("abort_idle_busy", int'(busy), 0);

    run_cmd(0, -1, 0, lat, bok);
    expect_result("after_abort", lat, bok, 16384, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
